// File: rtl/io_responder.sv
// CPU-side I/O responder: buffered OUT queue toward an external consumer and a
// one-entry IN holding buffer from an external producer. Optional macro IO_DISPLAY_EN.
module io_responder #(
  parameter int DATA_W   = 16,
  parameter int TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_en,
  input  logic [DATA_W-1:0] out_data,
  input  logic              in_en,
  output logic [DATA_W-1:0] in_data,
  output logic              stall,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic [DATA_W-1:0] display
);

  localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TX_DEPTH);

  generate
    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("io_responder: TX_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic [DATA_W-1:0] mem [TX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              push;
  logic              pop;
  logic              stall_out;

  logic [DATA_W-1:0] rx_buf;
  logic              rx_full;
  logic              rx_load;
  logic              consume;
  logic              stall_in;
  state_t            state;
  state_t            state_nxt;

  // OUT queue: push decision uses the registered count, so a same-cycle pop
  // never frees a slot for the push that is being stalled.
  assign full      = (count == FULL_CNT);
  assign push      = out_en & ~full;
  assign stall_out = out_en & full;
  assign tx_valid  = (count != '0);
  assign tx_data   = mem[rd_ptr];
  assign pop       = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= out_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // IN holding buffer: load only when empty, consume only when full, so the
  // two can never coincide.
  assign rx_ready = ~rx_full;
  assign rx_load  = rx_valid & ~rx_full;

  always_ff @(posedge clk) begin
    if (rx_load) rx_buf <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_full <= 1'b0;
      state   <= ST_IDLE;
    end else begin
      state <= state_nxt;
      if (rx_load)      rx_full <= 1'b1;
      else if (consume) rx_full <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    stall_in  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_en) begin
          if (rx_full) begin
            consume = 1'b1;
          end else begin
            stall_in  = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!in_en) begin
          state_nxt = ST_IDLE;
        end else if (rx_full) begin
          consume   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stall_in = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs are masked while reset is held so the CPU sees a
  // quiet interface even if its strobes are still asserted.
  assign stall   = ~reset & (stall_out | stall_in);
  assign in_data = (consume & ~reset) ? rx_buf : '0;

`ifdef IO_DISPLAY_EN
  logic [DATA_W-1:0] display_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     display_q <= '0;
    else if (push) display_q <= out_data;
  end

  assign display = display_q;
`else
  assign display = '0;
`endif

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the width of the CPU data word and the external data word.
REQ-002 SHALL have parameter TX_DEPTH, default 4, giving the number of OUT FIFO entries; the value SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port out_en, input, 1 bit: CPU OUT-instruction strobe.
REQ-006 SHALL have port out_data, input, DATA_W: the CPU operand for OUT.
REQ-007 SHALL have port in_en, input, 1 bit: CPU IN-instruction strobe.
REQ-008 SHALL have port in_data, output, DATA_W: the IN result to the CPU register write path.
REQ-009 SHALL have port stall, output, 1 bit: the CPU holds PC and the instruction while this is high.
REQ-010 SHALL have ports tx_valid (output, 1), tx_data (output, DATA_W) and tx_ready (input, 1): the external consumer handshake.
REQ-011 SHALL have ports rx_valid (input, 1), rx_data (input, DATA_W) and rx_ready (output, 1): the external producer handshake.
REQ-012 SHALL have port display, output, DATA_W: the last value written by OUT.

Function
REQ-013 SHALL implement the OUT path as a TX_DEPTH-entry FIFO with read and write pointers wrapping modulo TX_DEPTH and a count ranging 0..TX_DEPTH.
REQ-014 SHALL push out_data in the same cycle when out_en=1 and count<TX_DEPTH, with stall low for that push.
REQ-015 SHALL, when out_en=1 and count==TX_DEPTH, assert stall combinationally and not push; a pop in that same cycle SHALL NOT allow a push until the next cycle.
REQ-016 SHALL drive tx_valid=(count>0) and tx_data=the FIFO head, with a pop on tx_valid&tx_ready and no empty-FIFO bypass, so data written by OUT appears on tx_valid no earlier than the next cycle.
REQ-017 SHALL, on a simultaneous push and pop with 0<count<TX_DEPTH, leave count unchanged and advance both pointers.
REQ-018 SHALL implement the IN path as a one-entry rx holding buffer with rx_ready=~rx_full; the buffer SHALL load rx_data on rx_valid&rx_ready.
REQ-019 SHALL implement an IN state machine with states IDLE and WAIT.
REQ-020 SHALL, in IDLE with in_en=1 and rx_full=1, drive in_data=the buffer, keep stall low, clear rx_full at the edge, and stay in IDLE.
REQ-021 SHALL, in IDLE with in_en=1 and rx_full=0, assert stall and move to WAIT.
REQ-022 SHALL, in WAIT, keep stall high until rx_full=1, then deliver the buffer exactly as in REQ-020 and return to IDLE; a buffer load and its consumption SHALL NOT occur in the same cycle.
REQ-023 SHALL, in WAIT with in_en dropped to 0, return to IDLE without consuming the buffer.
REQ-024 SHALL drive in_data=0 whenever no IN is being completed.
REQ-025 SHALL assert stall as the OR of the OUT-full stall and the IN-wait stall when out_en and in_en are both high, with each path acting independently.

Reset
REQ-026 SHALL, while reset=1 and regardless of clk, force: count=0; both pointers=0; rx_full=0; state=IDLE; display=0.
REQ-027 SHALL, under reset, produce the outputs tx_valid=0, rx_ready=1, stall=0 and in_data=0.
REQ-028 SHALL discard a pending IN (WAIT) and all queued OUT data when reset is asserted mid-operation.

Configuration
REQ-029 SHALL, with macro IO_DISPLAY_EN defined, load display with out_data on every accepted push (REQ-014).
REQ-030 SHALL, without IO_DISPLAY_EN, tie display to 0 and include no display register; all other behaviour SHALL be identical in both builds.

Verification
REQ-031 SHALL cover: out_en with out_data=0x1234 into an empty FIFO and tx_ready=1 -> next cycle tx_valid=1, tx_data=0x1234; the following cycle tx_valid=0; display=0x1234 with IO_DISPLAY_EN.
REQ-032 SHALL cover: tx_ready=0 and five consecutive out_en (0x0001..0x0005) -> pushes 1-4 accepted, stall=1 on the fifth; raising tx_ready -> 0x0005 accepted the cycle after the first pop, and order 1..5 preserved.
REQ-033 SHALL cover: rx_valid with rx_data=0xBEEF, then in_en -> in_data=0xBEEF, stall=0, and rx_ready back to 1 next cycle.
REQ-034 SHALL cover: in_en with an empty buffer -> stall=1 for 3 cycles, rx_valid with 0x00A5 -> the next cycle in_data=0x00A5, stall=0, state IDLE.
REQ-035 SHALL cover: reset pulsed during WAIT with 3 FIFO entries -> immediately stall=0, tx_valid=0, rx_ready=1, display=0.
REQ-036 SHALL cover: push and pop in the same cycle at count=2 -> count stays 2, data order intact across pointer wrap.
